// File: rtl/vec_cpu_pkg.sv
// rtl/vec_cpu_pkg.sv - shared memory-op encodings, sequencer states and default widths
package vec_cpu_pkg;

  localparam int DEF_VEC_LEN = 8;
  localparam int DEF_ELEM_W  = 8;

  // op[1]=1 is a load, op[0]=1 is a single-element (scalar) access
  typedef enum logic [1:0] {
    MEM_GV = 2'b00,
    MEM_GE = 2'b01,
    MEM_CV = 2'b10,
    MEM_CE = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    VMEM_IDLE   = 2'd0,
    VMEM_REQ    = 2'd1,
    VMEM_WAIT_R = 2'd2,
    VMEM_DONE   = 2'd3
  } vmem_state_e;

endpackage

// File: rtl/vmem_timeout_cnt.sv
// rtl/vmem_timeout_cnt.sv - handshake watchdog; expired_o holds once TIMEOUT idle cycles have elapsed
module vmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clr_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vec_mem_sequencer.sv
// rtl/vec_mem_sequencer.sv - sequences CV/CE/GV/GE accesses onto the data-memory port
// Optional handshake watchdog and mem_err reporting under VMEM_TIMEOUT_EN.
module vec_mem_sequencer
  import vec_cpu_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int ELEM_W  = DEF_ELEM_W,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cl_mem_st,
  input  logic [1:0]                cl_mem_op,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [VEC_LEN*ELEM_W-1:0] vec_wdata,
  input  logic [ELEM_W-1:0]         esc_wdata,
  output logic                      mem_rdy,
  output logic                      mem_err,
  output logic [VEC_LEN*ELEM_W-1:0] vec_rdata,
  output logic [ELEM_W-1:0]         esc_rdata,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_W-1:0]         dmem_addr,
  output logic [ELEM_W-1:0]         dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [ELEM_W-1:0]         dmem_rdata
);

  localparam int IDX_W = $clog2(VEC_LEN + 1);
  localparam int SEL_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("vec_mem_sequencer: TIMEOUT must be at least 1");
  end

  vmem_state_e               state_q, state_d;
  mem_op_e                   op_q, op_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [VEC_LEN*ELEM_W-1:0] vwdata_q, vwdata_d, vrdata_q, vrdata_d;
  logic [ELEM_W-1:0]         ewdata_q, ewdata_d, erdata_q, erdata_d;
  logic [IDX_W-1:0]          idx_q, idx_d, last_idx;
  logic [SEL_W-1:0]          sel;
  logic                      tmo, abort, is_last;

  assign sel      = idx_q[SEL_W-1:0];
  assign last_idx = op_q[0] ? '0 : IDX_W'(VEC_LEN - 1);
  assign is_last  = (idx_q == last_idx);
  assign abort    = tmo && (((state_q == VMEM_REQ) && !dmem_gnt) ||
                            ((state_q == VMEM_WAIT_R) && !dmem_rvalid));

  assign dmem_req   = (state_q == VMEM_REQ);
  assign dmem_we    = (state_q == VMEM_REQ) && !op_q[1];
  assign dmem_addr  = base_q + ADDR_W'(idx_q);
  assign dmem_wdata = op_q[0] ? ewdata_q : vwdata_q[sel*ELEM_W +: ELEM_W];
  assign mem_rdy    = (state_q == VMEM_DONE);
  assign vec_rdata  = vrdata_q;
  assign esc_rdata  = erdata_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    vwdata_d = vwdata_q;
    ewdata_d = ewdata_q;
    vrdata_d = vrdata_q;
    erdata_d = erdata_q;
    idx_d    = idx_q;
    unique case (state_q)
      VMEM_IDLE: begin
        if (cl_mem_st) begin
          state_d  = VMEM_REQ;
          op_d     = mem_op_e'(cl_mem_op);
          base_d   = base_addr;
          vwdata_d = vec_wdata;
          ewdata_d = esc_wdata;
          idx_d    = '0;
          if (mem_op_e'(cl_mem_op) == MEM_CV) vrdata_d = '0;
          if (mem_op_e'(cl_mem_op) == MEM_CE) erdata_d = '0;
        end
      end
      VMEM_REQ: begin
        if (dmem_gnt) begin
          if (op_q[1]) begin
            state_d = VMEM_WAIT_R;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = is_last ? VMEM_DONE : VMEM_REQ;
          end
        end else if (abort) begin
          state_d = VMEM_DONE;
        end
      end
      VMEM_WAIT_R: begin
        if (dmem_rvalid) begin
          if (op_q == MEM_CE) erdata_d = dmem_rdata;
          else vrdata_d[sel*ELEM_W +: ELEM_W] = dmem_rdata;
          idx_d   = idx_q + IDX_W'(1);
          state_d = is_last ? VMEM_DONE : VMEM_REQ;
        end else if (abort) begin
          state_d = VMEM_DONE;
        end
      end
      VMEM_DONE: state_d = VMEM_IDLE;
      default:   state_d = VMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= VMEM_IDLE;
      op_q     <= MEM_GV;
      base_q   <= '0;
      vwdata_q <= '0;
      ewdata_q <= '0;
      vrdata_q <= '0;
      erdata_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      vwdata_q <= vwdata_d;
      ewdata_q <= ewdata_d;
      vrdata_q <= vrdata_d;
      erdata_q <= erdata_d;
      idx_q    <= idx_d;
    end
  end

`ifdef VMEM_TIMEOUT_EN
  logic err_q;

  vmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     ((state_q == VMEM_REQ) || (state_q == VMEM_WAIT_R)),
    .clr_i     (dmem_gnt || dmem_rvalid),
    .expired_o (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end else if (state_q == VMEM_IDLE) begin
      err_q <= 1'b0;
    end
  end

  assign mem_err = err_q && (state_q == VMEM_DONE);
`else
  assign tmo     = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb/tb_vec_mem_sequencer.sv - scoreboard bench for vec_mem_sequencer with a delay-programmable memory model
module tb_vec_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cl_mem_st = 1'b0;
  logic [1:0]  cl_mem_op = 2'b00;
  logic [15:0] base_addr = 16'h0;
  logic [63:0] vec_wdata = 64'h0;
  logic [7:0]  esc_wdata = 8'h0;
  logic        mem_rdy, mem_err, dmem_req, dmem_we;
  logic [63:0] vec_rdata;
  logic [7:0]  esc_rdata, dmem_wdata;
  logic [15:0] dmem_addr;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [7:0]  dmem_rdata = 8'h0;

  vec_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cl_mem_st(cl_mem_st), .cl_mem_op(cl_mem_op),
    .base_addr(base_addr), .vec_wdata(vec_wdata), .esc_wdata(esc_wdata),
    .mem_rdy(mem_rdy), .mem_err(mem_err), .vec_rdata(vec_rdata), .esc_rdata(esc_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic [63:0] vec;
    logic [7:0]  esc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] exp_wr[$];
  logic [63:0] m_vec = 64'h0;
  logic [7:0]  m_esc = 8'h0;

  // memory model: gnt after gnt_wait idle REQ cycles, rvalid rd_lat cycles after gnt, data = addr[7:0]
  int          gnt_wait = 0;
  int          rd_lat = 1;
  int          g_cnt = 0;
  int          rv_cnt = 0;
  logic        rd_pend = 1'b0;
  logic        rv_inject = 1'b0;
  logic [7:0]  rd_data = 8'h0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  prev_wd = 8'h0;
  logic [23:0] w;

  always @(negedge clk) begin
    dmem_rvalid = 1'b0;
    if (rd_pend) begin
      if (rv_cnt >= rd_lat) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd_data;
        rd_pend     = 1'b0;
      end else begin
        rv_cnt++;
      end
    end
    if (rv_inject && dmem_req) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = 8'hEE;
    end
    if (dmem_req && prev_req && !prev_gnt) begin
      check("hold_addr", dmem_addr, prev_addr);
      check("hold_we", dmem_we, prev_we);
      check("hold_wdata", dmem_wdata, prev_wd);
    end
    dmem_gnt = 1'b0;
    if (!dmem_req) begin
      g_cnt = 0;
    end else if (g_cnt >= gnt_wait) begin
      dmem_gnt = 1'b1;
      g_cnt = 0;
      if (dmem_we) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", dmem_addr, w[23:8]);
          check("wr_data", dmem_wdata, w[7:0]);
        end
      end else begin
        rd_pend = 1'b1;
        rv_cnt  = 1;
        rd_data = dmem_addr[7:0];
      end
    end else begin
      g_cnt++;
    end
    prev_req  = dmem_req;
    prev_gnt  = dmem_gnt;
    prev_we   = dmem_we;
    prev_addr = dmem_addr;
    prev_wd   = dmem_wdata;
  end

  task automatic run_op(input logic [1:0] op, input logic [15:0] base, input logic [63:0] vw,
                        input logic [7:0] ew, input int gw, input int rl, input int lat, input logic err);
    exp_t e;
    int   n;
    int   cyc;
    logic seen;
    n = op[0] ? 1 : 8;
    gnt_wait = gw;
    rd_lat   = rl;
    if (!op[1]) begin
      for (int i = 0; i < n; i++) exp_wr.push_back({base + 16'(i), op[0] ? ew : vw[i*8 +: 8]});
    end
    if (op == 2'b10) begin
      m_vec = 64'h0;
      if (!err) for (int i = 0; i < 8; i++) m_vec[i*8 +: 8] = 8'(base + 16'(i));
    end
    if (op == 2'b11) m_esc = err ? 8'h00 : base[7:0];
    e.lat = lat; e.vec = m_vec; e.esc = m_esc; e.err = err;
    exp_q.push_back(e);
    @(negedge clk);
    cl_mem_op = op; base_addr = base; vec_wdata = vw; esc_wdata = ew; cl_mem_st = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      cl_mem_st = 1'b0;
      if (mem_rdy) seen = 1'b1;
    end
    if (!seen) begin
      check("rdy_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("latency", cyc, e.lat);
      check("vec_rdata", vec_rdata, e.vec);
      check("esc_rdata", esc_rdata, e.esc);
      check("mem_err", mem_err, e.err);
      check("writes_left", exp_wr.size(), 0);
      cl_mem_st = 1'b1;
      @(negedge clk);
      cl_mem_st = 1'b0;
      check("rdy_one_cycle", mem_rdy, 0);
      check("st_in_done_ignored", dmem_req, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    check("rst_mem_rdy", mem_rdy, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_vec_rdata", vec_rdata, 0);
    check("rst_esc_rdata", esc_rdata, 0);
    rst_n = 1'b1;

    run_op(2'b10, 16'h0010, 64'h0, 8'h00, 0, 1, 17, 1'b0);
    check("cv_vec_value", vec_rdata, 64'h1716151413121110);
    run_op(2'b00, 16'hFFFE, 64'h0807060504030201, 8'h00, 0, 1, 9, 1'b0);
    run_op(2'b11, 16'h1234, 64'h0, 8'h00, 3, 2, 7, 1'b0);
    check("ce_esc_value", esc_rdata, 8'h34);
    rv_inject = 1'b1;
    run_op(2'b01, 16'h0100, 64'h0, 8'hA5, 0, 1, 2, 1'b0);
    rv_inject = 1'b0;
    run_op(2'b10, 16'hFFFC, 64'h0, 8'h00, 1, 1, 25, 1'b0);
    run_op(2'b11, 16'hBEEF, 64'h0, 8'h00, 2, 1, 5, 1'b0);
    run_op(2'b00, 16'h0200, 64'hDEADBEEFCAFEF00D, 8'h00, 2, 1, 25, 1'b0);

    // reset while element 4 of a CV is being requested
    gnt_wait = 0; rd_lat = 1;
    @(negedge clk);
    cl_mem_op = 2'b10; base_addr = 16'h0020; cl_mem_st = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      cl_mem_st = 1'b0;
      if (dmem_req && dmem_addr == 16'h0024) seen = 1'b1;
    end
    check("reach_elem4", seen, 1);
    rst_n = 1'b0;
    #1;
    rd_pend = 1'b0;
    check("abort_req_drop", dmem_req, 0);
    check("abort_no_rdy", mem_rdy, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rdy_hold", mem_rdy, 0);
    end
    check("abort_vec_cleared", vec_rdata, 0);
    check("abort_esc_cleared", esc_rdata, 0);
    m_vec = 64'h0;
    m_esc = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", dmem_req, 0);
    check("post_reset_no_rdy", mem_rdy, 0);
    run_op(2'b10, 16'h0030, 64'h0, 8'h00, 0, 1, 17, 1'b0);

`ifdef VMEM_TIMEOUT_EN
    run_op(2'b11, 16'h0040, 64'h0, 8'h00, 1000000, 1, 257, 1'b1);
    gnt_wait = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
